// File: rtl/qam_fir_scheduler.sv
// Symbol FIFO plus zero-stuffing sequencer feeding the I/Q pulse-shaping FIR pair.
// One symbol sample per OSR filter samples; the delay line is flushed with zeros at burst end or underrun.
module qam_fir_scheduler #(
    parameter int SYM_W      = 3,
    parameter int OUT_W      = 8,
    parameter int OSR        = 100,
    parameter int SAMPLE_DIV = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FLUSH_SYMS = 2
) (
    input  logic                    axi_clk,
    input  logic                    axi_rst,
    input  logic                    enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [SYM_W-1:0] s_i,
    input  logic signed [SYM_W-1:0] s_q,
    input  logic                    s_last,
    output logic                    fir_valid,
    output logic signed [OUT_W-1:0] fir_i,
    output logic signed [OUT_W-1:0] fir_q,
    output logic                    fir_sym,
    output logic                    busy,
    output logic                    underrun,
    input  logic                    clr_underrun
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int PH_W  = $clog2(OSR);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FL_W  = $clog2(FLUSH_SYMS + 1);

    typedef struct packed {
        logic             last;
        logic [SYM_W-1:0] i;
        logic [SYM_W-1:0] q;
    } sym_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    function automatic logic signed [OUT_W-1:0] sext(input logic [SYM_W-1:0] v);
        return {{(OUT_W-SYM_W){v[SYM_W-1]}}, v};
    endfunction

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [PH_W-1:0]   ph;
    logic [FL_W-1:0]   fl_cnt;
    logic              fl_last;
    logic              last_pend;

    sym_t              mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_nxt;
    sym_t              head;
    logic              wr, pop, empty;

    logic              strobe, slot, fl_done;
    logic [PH_W-1:0]   ph_nxt;

    assign strobe  = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign slot    = (ph == '0);
    assign ph_nxt  = (ph == PH_W'(OSR - 1)) ? '0 : ph + 1'b1;
    assign fl_done = ((fl_cnt + 1'b1) == FL_W'(FLUSH_SYMS));
    assign wr      = s_valid && s_ready;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pop decision is shared by the FIFO pointers and the sequencer below.
    always_comb begin
        pop = 1'b0;
        if (strobe && enable && !empty) begin
            case (state)
                IDLE:    pop = 1'b1;
                RUN:     pop = slot && !last_pend;
                FLUSH:   pop = slot && !fl_last && !fl_done;
                default: pop = 1'b0;
            endcase
        end
    end

    always_comb begin
        count_nxt = count;
        if (wr && !pop)      count_nxt = count + 1'b1;
        else if (!wr && pop) count_nxt = count - 1'b1;
    end

    always_ff @(posedge axi_clk) begin
        if (wr) mem[wr_ptr] <= {s_last, s_i, s_q};
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            s_ready <= 1'b0;
            div_cnt <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nxt;
            s_ready <= (count_nxt != (AW+1)'(FIFO_DEPTH));
            div_cnt <= strobe ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state     <= IDLE;
            ph        <= '0;
            fl_cnt    <= '0;
            fl_last   <= 1'b0;
            last_pend <= 1'b0;
            fir_valid <= 1'b0;
            fir_sym   <= 1'b0;
            fir_i     <= '0;
            fir_q     <= '0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            fir_valid <= 1'b0;
            fir_sym   <= 1'b0;
            // A set later in this block overrides the clear.
            if (clr_underrun) underrun <= 1'b0;
            if (strobe) begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            fir_valid <= 1'b1;
                            fir_sym   <= 1'b1;
                            fir_i     <= sext(head.i);
                            fir_q     <= sext(head.q);
                            last_pend <= head.last;
                            ph        <= PH_W'(1);
                            state     <= RUN;
                            busy      <= 1'b1;
                        end
                    end
                    RUN: begin
                        fir_valid <= 1'b1;
                        ph        <= ph_nxt;
                        if (pop) begin
                            fir_sym   <= 1'b1;
                            fir_i     <= sext(head.i);
                            fir_q     <= sext(head.q);
                            last_pend <= head.last;
                        end else begin
                            fir_i <= '0;
                            fir_q <= '0;
                            if (slot) begin
                                state   <= FLUSH;
                                fl_cnt  <= '0;
                                fl_last <= last_pend;
                                if (!last_pend && enable) underrun <= 1'b1;
                            end
                        end
                    end
                    FLUSH: begin
                        if (slot && fl_done) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            ph        <= '0;
                            fl_cnt    <= '0;
                            last_pend <= 1'b0;
                        end else begin
                            fir_valid <= 1'b1;
                            ph        <= ph_nxt;
                            if (pop) begin
                                fir_sym   <= 1'b1;
                                fir_i     <= sext(head.i);
                                fir_q     <= sext(head.q);
                                last_pend <= head.last;
                                state     <= RUN;
                            end else begin
                                fir_i <= '0;
                                fir_q <= '0;
                                if (slot) fl_cnt <= fl_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/qam_fir_scheduler.md
Name: qam_fir_scheduler

Overview:
- Sequences the I/Q pulse-shaping FIR pair. Buffers mapped QAM-16 symbols and zero-stuffs them up to the filter sample rate: one symbol sample followed by OSR-1 zero samples.
- Flushes the filter delay line with zeros at end of burst or on underrun.
- Sits between the symbol mapper and the I/Q FIR instances. fir_valid drives both filters' s_axis_data_tvalid; fir_i and fir_q drive their s_axis_data_tdata.

Parameters:
- SYM_W, 3: signed symbol width; QAM-16 levels are ±1 and ±3.
- OUT_W, 8: FIR input tdata width; symbols are sign-extended to this width.
- OSR, 100: samples per symbol (31.25 MHz / 0.3125 MHz).
- SAMPLE_DIV, 4: axi_clk cycles per filter sample. Must be ≥2.
- FIFO_DEPTH, 4: symbol FIFO entries. Power of 2.
- FLUSH_SYMS, 2: zero symbol periods emitted in FLUSH. Must be ≥1; 100 samples exceeds the FIR start-up latency of 20.

Ports:
- axi_clk in 1: clock.
- axi_rst in 1: reset, asynchronous, active-high.
- enable in 1: allows start and continuation of symbol pops.
- s_valid in 1: symbol valid.
- s_ready out 1: FIFO not full.
- s_i in SYM_W: symbol I, signed.
- s_q in SYM_W: symbol Q, signed.
- s_last in 1: marks the final symbol of a burst.
- fir_valid out 1: one-cycle sample strobe to the FIRs.
- fir_i out OUT_W: FIR I sample, signed.
- fir_q out OUT_W: FIR Q sample, signed.
- fir_sym out 1: high with fir_valid when the sample is a symbol (non-zero-stuffed) sample.
- busy out 1: state != IDLE.
- underrun out 1: sticky underrun flag.
- clr_underrun in 1: clears underrun.

Behaviour:
- Reset (async, axi_rst=1):
  - FIFO emptied, s_ready=0, state=IDLE.
  - All counters 0.
  - fir_valid, fir_sym, busy, underrun = 0; fir_i = fir_q = 0.
  - s_ready rises the first cycle after reset deasserts.
  - Reset mid-burst discards all symbols with no flush.
- FIFO:
  - Write on s_valid && s_ready, storing {s_last, s_i, s_q}.
  - s_ready = !full, registered from occupancy.
  - Simultaneous write and pop when full is not possible, since s_ready=0. Simultaneous write and pop at any other level keeps the count unchanged.
- Sample strobe:
  - div_cnt counts 0..SAMPLE_DIV-1, free-running from reset.
  - strobe occurs when div_cnt == SAMPLE_DIV-1.
  - All FSM decisions happen only on strobe.
- Phase:
  - ph counts 0..OSR-1, advancing on strobe in RUN and FLUSH. It wraps to 0.
  - ph==0 is the symbol slot.
- Outputs:
  - All outputs are registered.
  - On any strobe that emits a sample, the next cycle has fir_valid=1 with fir_i/fir_q set; otherwise fir_valid=0.
  - fir_i/fir_q hold their last value when fir_valid=0.
  - Non-slot samples are 0.
  - The symbol sample is sign-extended: −3 → 8'hFD, +1 → 8'h01.
- FSM, IDLE:
  - On strobe with enable && !empty: pop, emit the symbol (fir_sym=1), set ph=1 and go to RUN.
  - Otherwise no emit.
- FSM, RUN:
  - Every strobe emits.
  - At slot, if last_pend=1: emit zero, go to FLUSH with fl_cnt=0 and fl_last=1.
  - At slot, else if enable && !empty: pop and emit the symbol. last_pend is set to the popped last bit.
  - At slot, else (empty, or enable=0): emit zero, go to FLUSH with fl_last=0. Set underrun only if enable=1.
- FSM, FLUSH:
  - Every strobe emits zero until exit.
  - At each slot after the entry slot, fl_cnt increments.
  - When fl_cnt reaches FLUSH_SYMS at a slot: no emit; go to IDLE with ph=0 and last_pend=0.
  - At a slot with fl_last=0, enable && !empty, and before completion: pop, emit the symbol and return to RUN (resume after underrun).
  - A burst flush (fl_last=1) always completes before the next burst starts.
- underrun: set has priority over simultaneous clr_underrun.
- busy = (state != IDLE).

Test Plan:
- Reset, then push 4 symbols (I/Q = +1/−3, +3/+1, −1/−1, −3/+3; last on the 4th) → s_ready drops at 4 entries.
  - 400 samples follow, then 200 zero samples, one fir_valid every 4 clocks.
  - fir_sym is set on samples 0, 100, 200, 300; first values fir_i=8'h01, fir_q=8'hFD.
  - busy falls after sample 599; underrun=0.
- Push 2 symbols without last, then stall → sample 200 is zero and underrun=1.
  - Push a symbol before sample 300 → it emits at sample 300; state RUN again.
- Underrun with no further input → exactly FLUSH_SYMS*100=200 zero samples, then IDLE. Assert clr_underrun on the same cycle as a new underrun set → underrun stays 1.
- enable=0 with FIFO non-empty in IDLE → no fir_valid. Deassert enable mid-RUN → flush entered at next slot, underrun stays 0.
- Push a new burst during a last-flush → first new symbol appears only after flush completes: the strobe following the IDLE entry strobe.
- Assert axi_rst mid-RUN → all outputs 0 and busy=0 asynchronously. After release, the FIFO is empty and no fir_valid occurs until new input arrives.
